// File: rtl/font_arb_pkg.sv
// Shared types and constants for the font ROM arbiter.
package font_arb_pkg;

  localparam int unsigned FONT_ADDR_W = 12;
  localparam int unsigned FONT_DATA_W = 8;

  // Requester identifiers
  localparam logic ID_TITLE = 1'b0;
  localparam logic ID_HUD   = 1'b1;

  // Issue tag travelling alongside a ROM read
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/font_rom_arbiter_tag_delay.sv
// Fixed-depth shift register carrying issue tags in step with ROM data.
module tag_delay
  import font_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  localparam int unsigned LINE_W = DEPTH * TAG_W;

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;

  // Shift the new tag in at the bottom; the oldest drops off the top
  always_comb begin
    line_d = LINE_W'({line_q, tag_in});
  end

  // Delay line storage, cleared so reset discards in-flight reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign tag_out = line_q[LINE_W-1 -: TAG_W];

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin share of the font ROM between title and HUD text renderers.
module font_rom_arbiter
  import font_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = FONT_ADDR_W,
  parameter int unsigned DATA_W  = FONT_DATA_W,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  // One stage to register the address plus ROM_LAT stages of ROM latency
  localparam int unsigned DEPTH = ROM_LAT + 1;

  logic              last_q, last_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  tag_t              tag_in;
  tag_t              tag_out;

  // Grant: lone requester always wins; on a tie the one not granted last wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && (!req1 || (last_q == ID_HUD))) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Issue: capture granted address, update priority pointer, launch tag
  always_comb begin
    last_d       = last_q;
    rom_addr_d   = rom_addr_q;
    tag_in.valid = 1'b0;
    tag_in.id    = ID_TITLE;
    if (gnt0) begin
      last_d       = ID_TITLE;
      rom_addr_d   = addr0;
      tag_in.valid = 1'b1;
      tag_in.id    = ID_TITLE;
    end else if (gnt1) begin
      last_d       = ID_HUD;
      rom_addr_d   = addr1;
      tag_in.valid = 1'b1;
      tag_in.id    = ID_HUD;
    end
  end

  tag_delay #(
    .DEPTH (DEPTH)
  ) u_tag_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Return demux: steer ROM data to the owner of the emerging tag
  always_comb begin
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (tag_out.valid) begin
      if (tag_out.id == ID_HUD) begin
        rvalid1_d = 1'b1;
        rdata1_d  = rom_data;
      end else begin
        rvalid0_d = 1'b1;
        rdata0_d  = rom_data;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= ID_HUD;
      rom_addr_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      last_q     <= last_d;
      rom_addr_q <= rom_addr_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter; four instances cover ROM_LAT 0..3.
module tb_font_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [11:0] addr0, addr1;

  logic [3:0]  gnt0_v, gnt1_v, rv0_v, rv1_v;
  logic [7:0]  rd0_a [4];
  logic [7:0]  rd1_a [4];
  logic [11:0] ra_a  [4];

  int total;
  int bad;

  // Glyph ROM contents: low byte xor the replicated high nibble
  function automatic logic [7:0] rom_f(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [11:0] d1, d2, d3, sel;
    logic [7:0]  rdat;

    always_ff @(posedge clk) begin
      d1 <= ra_a[g];
      d2 <= d1;
      d3 <= d2;
    end

    always_comb begin
      case (g)
        0:       sel = ra_a[g];
        1:       sel = d1;
        2:       sel = d2;
        default: sel = d3;
      endcase
    end

    assign rdat = rom_f(sel);

    font_rom_arbiter #(
      .ADDR_W  (12),
      .DATA_W  (8),
      .ROM_LAT (g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .addr0    (addr0),
      .addr1    (addr1),
      .gnt0     (gnt0_v[g]),
      .gnt1     (gnt1_v[g]),
      .rvalid0  (rv0_v[g]),
      .rvalid1  (rv1_v[g]),
      .rdata0   (rd0_a[g]),
      .rdata1   (rd1_a[g]),
      .rom_addr (ra_a[g]),
      .rom_data (rdat)
    );
  end

  typedef struct {
    bit          pre_rst;
    bit          r0, r1;
    logic [11:0] a0, a1;
    bit          g0, g1;
    logic [11:0] ra;
    bit          v0, v1;
    logic [7:0]  d0, d1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit pre, bit r0, bit r1, logic [11:0] a0, logic [11:0] a1,
                              bit g0, bit g1, logic [11:0] ra, bit v0, bit v1,
                              logic [7:0] d0, logic [7:0] d1);
    vec_t v;
    v.pre_rst = pre; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
    v.g0 = g0; v.g1 = g1; v.ra = ra; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Hold reset for a cycle with both requests high, checking forced-zero outputs
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 12'h123; addr1 = 12'h456;
    @(negedge clk);
    chk("rst gnt0", 32'(gnt0_v[1]), 32'd0);
    chk("rst gnt1", 32'(gnt1_v[1]), 32'd0);
    chk("rst rom_addr", 32'(ra_a[1]), 32'd0);
    chk("rst rvalid", 32'({rv0_v[1], rv1_v[1]}), 32'd0);
    chk("rst rdata", 32'({rd0_a[1], rd1_a[1]}), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    rst_n = 1'b1;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    if (v.pre_rst) do_reset();
    @(posedge clk); #1;
    req0 = v.r0; req1 = v.r1; addr0 = v.a0; addr1 = v.a1;
    @(negedge clk);
    chk($sformatf("row%0d gnt0", idx), 32'(gnt0_v[1]), 32'(v.g0));
    chk($sformatf("row%0d gnt1", idx), 32'(gnt1_v[1]), 32'(v.g1));
    chk($sformatf("row%0d rom_addr", idx), 32'(ra_a[1]), 32'(v.ra));
    chk($sformatf("row%0d rvalid0", idx), 32'(rv0_v[1]), 32'(v.v0));
    chk($sformatf("row%0d rvalid1", idx), 32'(rv1_v[1]), 32'(v.v1));
    chk($sformatf("row%0d rdata0", idx), 32'(rd0_a[1]), 32'(v.d0));
    chk($sformatf("row%0d rdata1", idx), 32'(rd1_a[1]), 32'(v.d1));
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    #2 rst_n = 1'b0;

    //             pre r0 r1 a0       a1       g0 g1 ra       v0 v1 d0     d1
    // Single title read of 'A' row 0
    tbl.push_back(mk(1, 1, 0, 12'h410, 12'h000, 1, 0, 12'h000, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h410, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h410, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h410, 1, 0, 8'h54, 8'h00));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h410, 0, 0, 8'h54, 8'h00));
    // Contention: alternate starting with requester 0
    tbl.push_back(mk(1, 1, 1, 12'h401, 12'h501, 1, 0, 12'h000, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 1, 12'h402, 12'h501, 0, 1, 12'h401, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 1, 12'h402, 12'h502, 1, 0, 12'h501, 0, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, 1, 12'h403, 12'h502, 0, 1, 12'h402, 1, 0, 8'h45, 8'h00));
    tbl.push_back(mk(0, 1, 1, 12'h403, 12'h503, 1, 0, 12'h502, 0, 1, 8'h45, 8'h54));
    tbl.push_back(mk(0, 1, 1, 12'h404, 12'h503, 0, 1, 12'h403, 1, 0, 8'h46, 8'h54));
    tbl.push_back(mk(0, 1, 1, 12'h404, 12'h504, 1, 0, 12'h503, 0, 1, 8'h46, 8'h57));
    tbl.push_back(mk(0, 1, 1, 12'h405, 12'h504, 0, 1, 12'h404, 1, 0, 8'h47, 8'h57));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h504, 0, 1, 8'h47, 8'h56));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h504, 1, 0, 8'h40, 8'h56));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h504, 0, 1, 8'h40, 8'h51));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h504, 0, 0, 8'h40, 8'h51));
    // Title wins, then HUD wins a tie while title raises and withdraws
    tbl.push_back(mk(0, 1, 0, 12'h4F0, 12'h000, 1, 0, 12'h504, 0, 0, 8'h40, 8'h51));
    tbl.push_back(mk(0, 1, 1, 12'h4F1, 12'h5F0, 0, 1, 12'h4F0, 0, 0, 8'h40, 8'h51));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h5F0, 0, 0, 8'h40, 8'h51));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h5F0, 1, 0, 8'hB4, 8'h51));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h5F0, 0, 1, 8'hB4, 8'hA5));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h5F0, 0, 0, 8'hB4, 8'hA5));
    tbl.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, 12'h5F0, 0, 0, 8'hB4, 8'hA5));

    foreach (tbl[i]) run_row(i, tbl[i]);

    // HUD streaming: 16 back-to-back grants and responses
    do_reset();
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      req1  = (i < 16);
      addr1 = 12'h300 + 12'(i);
      @(negedge clk);
      chk($sformatf("stream%0d gnt1", i), 32'(gnt1_v[1]), 32'(i < 16));
      chk($sformatf("stream%0d gnt0", i), 32'(gnt0_v[1]), 32'd0);
      chk($sformatf("stream%0d rvalid1", i), 32'(rv1_v[1]), 32'(i >= 3));
      chk($sformatf("stream%0d rvalid0", i), 32'(rv0_v[1]), 32'd0);
      if (i >= 3)
        chk($sformatf("stream%0d rdata1", i), 32'(rd1_a[1]), 32'(8'(i - 3) ^ 8'h33));
    end
    @(posedge clk); #1;
    req1 = 1'b0; addr1 = '0;

    // Reset one cycle after a grant discards the read
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; addr0 = 12'h410;
    @(negedge clk);
    chk("midrst grant", 32'(gnt0_v[1]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    chk("midrst gnt", 32'({gnt0_v[1], gnt1_v[1]}), 32'd0);
    chk("midrst rom_addr", 32'(ra_a[1]), 32'd0);
    chk("midrst rvalid", 32'({rv0_v[1], rv1_v[1]}), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("midrst T+2 rvalid0", 32'(rv0_v[1]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst T+3 rvalid0", 32'(rv0_v[1]), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 12'h420; addr1 = 12'h520;
    @(negedge clk);
    chk("midrst tie gnt0", 32'(gnt0_v[1]), 32'd1);
    chk("midrst tie gnt1", 32'(gnt1_v[1]), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;

    // ROM_LAT sweep: single title read seen by every instance
    do_reset();
    for (int off = 0; off < 7; off++) begin
      @(posedge clk); #1;
      req0  = (off == 0);
      addr0 = 12'h4A7;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("lat%0d off%0d rvalid0", k, off), 32'(rv0_v[k]), 32'(off == k + 2));
        chk($sformatf("lat%0d off%0d rvalid1", k, off), 32'(rv1_v[k]), 32'd0);
        if (off == k + 2)
          chk($sformatf("lat%0d rdata0", k), 32'(rd0_a[k]), 32'h0E3);
      end
    end
    req0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
